// File: rtl/fpu_pkg.sv
// Shared IEEE-754 single-precision field widths, result class encoding and classifier.
// Also holds the state type of the 2-entry skid buffer.
package fpu_pkg;

    localparam int FP_EXP_W   = 8;
    localparam int FP_MAN_W   = 23;
    localparam int FP_WORD_W  = 1 + FP_EXP_W + FP_MAN_W;
    localparam int FP_CLASS_W = 3;

    localparam logic [FP_CLASS_W-1:0] FP_CLASS_ZERO      = 3'd0;
    localparam logic [FP_CLASS_W-1:0] FP_CLASS_SUBNORMAL = 3'd1;
    localparam logic [FP_CLASS_W-1:0] FP_CLASS_NORMAL    = 3'd2;
    localparam logic [FP_CLASS_W-1:0] FP_CLASS_INF       = 3'd3;
    localparam logic [FP_CLASS_W-1:0] FP_CLASS_NAN       = 3'd4;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

    // Takes the word without its sign bit, since the class does not depend on it.
    function automatic logic [FP_CLASS_W-1:0] fp_classify(
        input logic [FP_EXP_W+FP_MAN_W-1:0] magnitude
    );
        logic [FP_EXP_W-1:0] exp_f;
        logic [FP_MAN_W-1:0] man_f;
        exp_f = magnitude[FP_MAN_W +: FP_EXP_W];
        man_f = magnitude[FP_MAN_W-1:0];
        if (exp_f == '0) begin
            return (man_f == '0) ? FP_CLASS_ZERO : FP_CLASS_SUBNORMAL;
        end else if (exp_f == '1) begin
            return (man_f == '0) ? FP_CLASS_INF : FP_CLASS_NAN;
        end
        return FP_CLASS_NORMAL;
    endfunction

endpackage

// File: rtl/fpu_skid_buf.sv
// Generic-width 2-entry valid/ready skid buffer with fully registered in_ready and out_valid.
// The main register always drives the output; the skid register catches one extra word.
module fpu_skid_buf
    import fpu_pkg::*;
#(
    parameter int W = 36
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    buf_state_t   state;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         accept;
    logic         consume;

    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready;
    assign out_data = main_q;

    // Occupancy FSM; in_ready and out_valid are updated alongside the state so both stay registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BUF_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            main_q    <= '0;
            skid_q    <= '0;
        end else begin
            case (state)
                BUF_EMPTY: begin
                    if (accept) begin
                        main_q    <= in_data;
                        out_valid <= 1'b1;
                        state     <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (accept && consume) begin
                        main_q <= in_data;
                    end else if (accept) begin
                        skid_q   <= in_data;
                        in_ready <= 1'b0;
                        state    <= BUF_FULL;
                    end else if (consume) begin
                        out_valid <= 1'b0;
                        state     <= BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (consume) begin
                        main_q   <= skid_q;
                        in_ready <= 1'b1;
                        state    <= BUF_ONE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= BUF_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/fpu_mult_result_stage.sv
// Registered result stage behind the FP multiplier: skid-buffered product, class and sticky flags.
// Define FPU_RESULT_STATS_EN to add the saturating stat_total / stat_ovf counters.
module fpu_mult_result_stage
    import fpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FP_WORD_W-1:0]  in_result,
    input  logic                  in_overflow,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FP_WORD_W-1:0]  out_result,
    output logic                  out_overflow,
    output logic [FP_CLASS_W-1:0] out_class,
    output logic                  flag_overflow,
    output logic                  flag_invalid,
    input  logic                  flag_clear
`ifdef FPU_RESULT_STATS_EN
    ,
    output logic [CNT_W-1:0]      stat_total,
    output logic [CNT_W-1:0]      stat_ovf
`endif
);

    localparam int ENTRY_W = FP_CLASS_W + 1 + FP_WORD_W;

    logic [FP_CLASS_W-1:0] in_class;
    logic [ENTRY_W-1:0]    in_entry;
    logic [ENTRY_W-1:0]    out_entry;
    logic                  accept;
    logic                  set_overflow;
    logic                  set_invalid;

    // Class is resolved once at accept and travels with the word through the buffer.
    assign in_class     = fp_classify(in_result[FP_WORD_W-2:0]);
    assign in_entry     = {in_class, in_overflow, in_result};
    assign accept       = in_valid && in_ready;
    assign set_overflow = accept && in_overflow;
    assign set_invalid  = accept && (in_class == FP_CLASS_NAN);

    fpu_skid_buf #(
        .W (ENTRY_W)
    ) u_skid_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_entry)
    );

    assign {out_class, out_overflow, out_result} = out_entry;

    // A set event outranks a simultaneous clear so that no new event is ever dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_overflow <= 1'b0;
            flag_invalid  <= 1'b0;
        end else begin
            if (set_overflow) begin
                flag_overflow <= 1'b1;
            end else if (flag_clear) begin
                flag_overflow <= 1'b0;
            end
            if (set_invalid) begin
                flag_invalid <= 1'b1;
            end else if (flag_clear) begin
                flag_invalid <= 1'b0;
            end
        end
    end

`ifdef FPU_RESULT_STATS_EN
    // Saturating counters; only reset clears them, flag_clear leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_total <= '0;
            stat_ovf   <= '0;
        end else begin
            if (accept && (stat_total != '1)) begin
                stat_total <= stat_total + 1'b1;
            end
            if (set_overflow && (stat_ovf != '1)) begin
                stat_ovf <= stat_ovf + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fpu_mult_result_stage.sv
// Self-checking bench for fpu_mult_result_stage: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the result stage.
module tb_fpu_mult_result_stage;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic [31:0] result;
        logic        ovf;
        logic [2:0]  cls;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_result = '0;
    logic        in_overflow = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_overflow;
    logic [2:0]  out_class;
    logic        flag_overflow;
    logic        flag_invalid;
    logic        flag_clear = 1'b0;
`ifdef FPU_RESULT_STATS_EN
    logic [CNT_W-1:0] stat_total;
    logic [CNT_W-1:0] stat_ovf;
`endif

    int total = 0;
    int bad   = 0;

    entry_t exp_q[$];
    logic   exp_flag_ovf = 1'b0;
    logic   exp_flag_inv = 1'b0;
    int     exp_total    = 0;
    int     exp_ovf_cnt  = 0;

    fpu_mult_result_stage #(
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_result     (in_result),
        .in_overflow   (in_overflow),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_class     (out_class),
        .flag_overflow (flag_overflow),
        .flag_invalid  (flag_invalid),
        .flag_clear    (flag_clear)
`ifdef FPU_RESULT_STATS_EN
        ,
        .stat_total    (stat_total),
        .stat_ovf      (stat_ovf)
`endif
    );

    always #5 clk = ~clk;

    // Reference classification from the IEEE-754 field meanings.
    function automatic logic [2:0] ref_class(input logic [31:0] word);
        int e;
        int m;
        e = int'((word >> 23) & 32'hFF);
        m = int'(word & 32'h7F_FFFF);
        if (e == 0 && m == 0)   return 3'd0;
        if (e == 0)             return 3'd1;
        if (e == 255 && m == 0) return 3'd3;
        if (e == 255)           return 3'd4;
        return 3'd2;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        int sel;
        w   = $urandom;
        sel = int'($urandom_range(0, 5));
        if (sel == 0) w[30:23] = 8'h00;
        if (sel == 1) w[30:23] = 8'hFF;
        if ($urandom_range(0, 3) == 0) w[22:0] = '0;
        return w;
    endfunction

    // Advance the model by one clock using the current inputs, then move to 1 ns after the edge.
    task automatic tick();
        bit     acc;
        bit     cons;
        entry_t e;
        acc  = in_valid && (exp_q.size() < 2);
        cons = (exp_q.size() > 0) && out_ready;
        if (rst) begin
            exp_q.delete();
            exp_flag_ovf = 1'b0;
            exp_flag_inv = 1'b0;
            exp_total    = 0;
            exp_ovf_cnt  = 0;
        end else begin
            if (cons) void'(exp_q.pop_front());
            if (acc) begin
                e.result = in_result;
                e.ovf    = in_overflow;
                e.cls    = ref_class(in_result);
                exp_q.push_back(e);
                exp_total   = (exp_total < CNT_MAX) ? exp_total + 1 : CNT_MAX;
                if (in_overflow) exp_ovf_cnt = (exp_ovf_cnt < CNT_MAX) ? exp_ovf_cnt + 1 : CNT_MAX;
            end
            if (acc && in_overflow)             exp_flag_ovf = 1'b1;
            else if (flag_clear)                exp_flag_ovf = 1'b0;
            if (acc && ref_class(in_result) == 3'd4) exp_flag_inv = 1'b1;
            else if (flag_clear)                exp_flag_inv = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_result !== 32'h0 || out_overflow !== 1'b0 || out_class !== 3'd0) begin
            bad++; $display("[TB] FAIL reset_out_data got=%h/%b/%0d want=0/0/0", out_result, out_overflow, out_class);
        end
        total++; if (flag_overflow !== 1'b0 || flag_invalid !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_flags got=%b%b want=00", flag_overflow, flag_invalid);
        end
    endtask

    task automatic test_basic();
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        in_result   = 32'h40C0_0000;
        in_overflow = 1'b0;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_result !== 32'h40C0_0000) begin
            bad++; $display("[TB] FAIL basic_data got=%b/%h want=1/40c00000", out_valid, out_result);
        end
        total++; if (out_class !== 3'd2 || out_overflow !== 1'b0) begin
            bad++; $display("[TB] FAIL basic_class got=%0d/%b want=2/0", out_class, out_overflow);
        end
        total++; if (flag_overflow !== 1'b0 || flag_invalid !== 1'b0) begin
            bad++; $display("[TB] FAIL basic_flags got=%b%b want=00", flag_overflow, flag_invalid);
        end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_drain got=%b want=0", out_valid); end
        // zero and subnormal classes
        in_valid  = 1'b1;
        in_result = 32'h8000_0000;
        tick();
        in_result = 32'h0000_0001;
        total++; if (out_class !== 3'd0) begin bad++; $display("[TB] FAIL class_zero got=%0d want=0", out_class); end
        tick();
        in_valid = 1'b0;
        total++; if (out_class !== 3'd1) begin bad++; $display("[TB] FAIL class_subnormal got=%0d want=1", out_class); end
        tick();
    endtask

    task automatic test_overflow_sticky();
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        in_result   = 32'h7F80_0000;
        in_overflow = 1'b1;
        tick();
        in_overflow = 1'b0;
        in_result   = 32'h3F80_0000;
        total++; if (out_class !== 3'd3 || out_overflow !== 1'b1) begin
            bad++; $display("[TB] FAIL ovf_class got=%0d/%b want=3/1", out_class, out_overflow);
        end
        total++; if (flag_overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_flag_set got=%b want=1", flag_overflow); end
        for (int i = 0; i < 5; i++) tick();
        in_valid = 1'b0;
        total++; if (flag_overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_flag_sticky got=%b want=1", flag_overflow); end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_result = 32'h3F80_0000;
        tick();
        in_result = 32'h4000_0000;
        tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_in_ready got=%b want=0", in_ready); end
        in_result = 32'h4040_0000;
        for (int i = 0; i < 3; i++) tick();
        total++; if (out_valid !== 1'b1 || out_result !== 32'h3F80_0000 || in_ready !== 1'b0) begin
            bad++; $display("[TB] FAIL bp_hold got=%b/%h/%b want=1/3f800000/0", out_valid, out_result, in_ready);
        end
        out_ready = 1'b1;
        tick();
        total++; if (out_result !== 32'h4000_0000) begin bad++; $display("[TB] FAIL bp_order2 got=%h want=40000000", out_result); end
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_result !== 32'h4040_0000) begin
            bad++; $display("[TB] FAIL bp_order3 got=%b/%h want=1/40400000", out_valid, out_result);
        end
        tick();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL bp_empty got=%b/%b want=0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_flag_clear();
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        in_result  = 32'h7FC0_0000;
        flag_clear = 1'b1;
        tick();
        in_valid   = 1'b0;
        flag_clear = 1'b0;
        total++; if (flag_invalid !== 1'b1 || out_class !== 3'd4) begin
            bad++; $display("[TB] FAIL clr_set_wins got=%b/%0d want=1/4", flag_invalid, out_class);
        end
        total++; if (flag_overflow !== exp_flag_ovf) begin
            bad++; $display("[TB] FAIL clr_ovf_cleared got=%b want=%b", flag_overflow, exp_flag_ovf);
        end
        tick();
        tick();
        total++; if (flag_invalid !== 1'b1) begin bad++; $display("[TB] FAIL clr_inv_sticky got=%b want=1", flag_invalid); end
        flag_clear = 1'b1;
        tick();
        flag_clear = 1'b0;
        total++; if (flag_invalid !== 1'b0 || flag_overflow !== 1'b0) begin
            bad++; $display("[TB] FAIL clr_alone got=%b%b want=00", flag_overflow, flag_invalid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 2) != 0);
            in_result   = rand_word();
            in_overflow = ($urandom_range(0, 7) == 0);
            flag_clear  = ($urandom_range(0, 15) == 0);
            tick();
            total++; if (in_ready !== (exp_q.size() < 2) || out_valid !== (exp_q.size() > 0)) begin
                bad++; $display("[TB] FAIL rnd_hs cyc=%0d got=%b/%b want=%b/%b", i, in_ready, out_valid,
                                exp_q.size() < 2, exp_q.size() > 0);
            end
            if (exp_q.size() > 0) begin
                total++;
                if (out_result !== exp_q[0].result || out_overflow !== exp_q[0].ovf || out_class !== exp_q[0].cls) begin
                    bad++; $display("[TB] FAIL rnd_data cyc=%0d got=%h/%b/%0d want=%h/%b/%0d", i, out_result,
                                    out_overflow, out_class, exp_q[0].result, exp_q[0].ovf, exp_q[0].cls);
                end
            end
            total++; if (flag_overflow !== exp_flag_ovf || flag_invalid !== exp_flag_inv) begin
                bad++; $display("[TB] FAIL rnd_flags cyc=%0d got=%b%b want=%b%b", i, flag_overflow, flag_invalid,
                                exp_flag_ovf, exp_flag_inv);
            end
        end
        in_valid   = 1'b0;
        flag_clear = 1'b0;
    endtask

    task automatic test_reset_full();
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        in_overflow = 1'b1;
        in_result   = 32'h7FC0_0001;
        tick();
        tick();
        total++; if (in_ready !== 1'b0 || flag_overflow !== 1'b1) begin
            bad++; $display("[TB] FAIL rstfull_pre got=%b/%b want=0/1", in_ready, flag_overflow);
        end
        rst       = 1'b1;
        out_ready = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL rstfull_hs got=%b/%b want=0/1", out_valid, in_ready);
        end
        total++; if (flag_overflow !== 1'b0 || flag_invalid !== 1'b0) begin
            bad++; $display("[TB] FAIL rstfull_flags got=%b%b want=00", flag_overflow, flag_invalid);
        end
`ifdef FPU_RESULT_STATS_EN
        total++; if (stat_total !== '0 || stat_ovf !== '0) begin
            bad++; $display("[TB] FAIL rstfull_stats got=%0d/%0d want=0/0", stat_total, stat_ovf);
        end
`endif
        in_overflow = 1'b0;
        tick();
    endtask

`ifdef FPU_RESULT_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_result   = 32'h3F80_0000 + 32'(i);
            in_overflow = (i == 2 || i == 7 || i == 11);
            flag_clear  = (i == 15);
            tick();
        end
        in_valid    = 1'b0;
        in_overflow = 1'b0;
        flag_clear  = 1'b0;
        total++; if (stat_total !== CNT_W'(15) || stat_total !== CNT_W'(exp_total)) begin
            bad++; $display("[TB] FAIL stat_total got=%0d want=15", stat_total);
        end
        total++; if (stat_ovf !== CNT_W'(3) || stat_ovf !== CNT_W'(exp_ovf_cnt)) begin
            bad++; $display("[TB] FAIL stat_ovf got=%0d want=3", stat_ovf);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_overflow_sticky();
        test_backpressure();
        test_flag_clear();
        test_random();
        test_reset_full();
`ifdef FPU_RESULT_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
